alu_control_pipe: RTL

ALU_CONTROL_PIPE -- requirements
Module: alu_control_pipe

---
 rtl/alu_control_pipe_pkg.sv | 51 +++++
 rtl/alu_control_pipe_if.sv | 25 ++
 rtl/alu_control_pipe_decode.sv | 78 +++++++
 rtl/alu_control_pipe.sv | 94 +++++++++
 4 files changed

// File: rtl/alu_control_pipe_pkg.sv
// Shared definitions for the ALU control path: operation codes, RV32 opcodes
// and the control-pipe FSM encoding. The ALU datapath imports this package too.
package alu_control_pipe_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASS_B = 5'd10,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        HOLD     = 2'd1,
        DIV_WAIT = 2'd2
    } state_e;

    function automatic logic is_div_op(input alu_op_e op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_control_pipe_if.sv
// Instruction-in / ALU-op-out handshake bundle of the ALU control pipe.
interface alu_control_pipe_if #(
    parameter int unsigned P_ALUOP_W = 5
);
    logic                 i_Valid;
    logic                 o_Ready;
    logic [6:0]           iv_Opcode;
    logic [2:0]           iv_Funct3;
    logic [6:0]           iv_Funct7;
    logic                 o_Valid;
    logic                 i_Ready;
    logic [P_ALUOP_W-1:0] ov_AluOp;
    logic                 o_Illegal;
    logic                 o_Busy;

    modport master (
        output i_Valid, iv_Opcode, iv_Funct3, iv_Funct7, i_Ready,
        input  o_Ready, o_Valid, ov_AluOp, o_Illegal, o_Busy
    );

    modport slave (
        input  i_Valid, iv_Opcode, iv_Funct3, iv_Funct7, i_Ready,
        output o_Ready, o_Valid, ov_AluOp, o_Illegal, o_Busy
    );
endinterface

// File: rtl/alu_control_pipe_decode.sv
// Combinational RV32I(+M) decode of opcode/funct3/funct7 into an ALU op code.
module alu_decode
    import alu_control_pipe_pkg::*;
#(
    parameter bit P_M_EXT = 1'b1
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_op_e    code,
    output logic       illegal,
    output logic       is_div
);

    always_comb begin
        code    = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_STORE, OPC_AUIPC, OPC_JAL: code = ALU_ADD;
            OPC_JALR:   illegal = (funct3 != 3'b000);
            OPC_LUI:    code = ALU_PASS_B;
            OPC_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: code = ALU_SUB;
                    3'b100, 3'b101: code = ALU_SLT;
                    3'b110, 3'b111: code = ALU_SLTU;
                    default:        illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                // funct7 is immediate bits except for the shift encodings
                case (funct3)
                    3'b000: code = ALU_ADD;
                    3'b001: begin
                        if (funct7 == F7_BASE) code = ALU_SLL;
                        else                   illegal = 1'b1;
                    end
                    3'b010: code = ALU_SLT;
                    3'b011: code = ALU_SLTU;
                    3'b100: code = ALU_XOR;
                    3'b101: begin
                        if (funct7 == F7_BASE)     code = ALU_SRL;
                        else if (funct7 == F7_ALT) code = ALU_SRA;
                        else                       illegal = 1'b1;
                    end
                    3'b110: code = ALU_OR;
                    default: code = ALU_AND;
                endcase
            end
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000: code = ALU_ADD;
                        3'b001: code = ALU_SLL;
                        3'b010: code = ALU_SLT;
                        3'b011: code = ALU_SLTU;
                        3'b100: code = ALU_XOR;
                        3'b101: code = ALU_SRL;
                        3'b110: code = ALU_OR;
                        default: code = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000)      code = ALU_SUB;
                    else if (funct3 == 3'b101) code = ALU_SRA;
                    else                       illegal = 1'b1;
                end else if ((funct7 == F7_MULDIV) && P_M_EXT) begin
                    code = alu_op_e'({2'b10, funct3});
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) code = ALU_ADD;
        is_div = !illegal && is_div_op(code);
    end

endmodule

// File: rtl/alu_control_pipe.sv
// ALU control pipe: registers the decoded ALU op behind a valid/ready
// handshake and stalls DIV/REM results for a fixed countdown.
module alu_control_pipe
    import alu_control_pipe_pkg::*;
#(
    parameter bit          P_M_EXT      = 1'b1,
    parameter int unsigned P_DIV_CYCLES = 32,
    parameter int unsigned P_ALUOP_W    = 5
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Enb,
    alu_control_pipe_if.slave     bus
);

    localparam int unsigned           CNT_W    = $clog2(P_DIV_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(P_DIV_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    alu_op_e          op_q, op_d;
    logic             illegal_q, illegal_d;

    alu_op_e dec_code;
    logic    dec_illegal;
    logic    dec_is_div;
    logic    ready;
    logic    accept;

    alu_decode #(
        .P_M_EXT (P_M_EXT)
    ) u_decode (
        .opcode  (bus.iv_Opcode),
        .funct3  (bus.iv_Funct3),
        .funct7  (bus.iv_Funct7),
        .code    (dec_code),
        .illegal (dec_illegal),
        .is_div  (dec_is_div)
    );

    always_comb begin
        ready  = i_Enb & ((state_q == EMPTY) | ((state_q == HOLD) & bus.i_Ready));
        accept = i_Enb & bus.i_Valid & ready;

        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        illegal_d = illegal_q;

        if (i_Enb) begin
            case (state_q)
                HOLD:     if (bus.i_Ready) state_d = EMPTY;
                DIV_WAIT: begin
                    if (cnt_q == '0) state_d = HOLD;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                default:  ;
            endcase
        end

        // A new acceptance overrides the drain to EMPTY for back-to-back flow
        if (accept) begin
            op_d      = dec_code;
            illegal_d = dec_illegal;
            if (dec_is_div) begin
                state_d = DIV_WAIT;
                cnt_d   = CNT_LOAD;
            end else begin
                state_d = HOLD;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= EMPTY;
            cnt_q     <= '0;
            op_q      <= ALU_ADD;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.o_Ready   = ready;
    assign bus.o_Valid   = (state_q == HOLD);
    assign bus.o_Busy    = (state_q == DIV_WAIT);
    assign bus.o_Illegal = illegal_q;
    assign bus.ov_AluOp  = P_ALUOP_W'(op_q);

endmodule
